// File: rtl/gpio_irq_pkg.sv
// Shared types, register map and index helpers for the GPIO interrupt arbiter.
// Optional input filter is enabled with the GPIO_IRQ_DEBOUNCE_EN macro.
package gpio_irq_pkg;

    localparam int unsigned NUM_GPIO        = 72;
    localparam int unsigned BANK_W          = 32;
    localparam int unsigned NUM_BANKS       = (NUM_GPIO + BANK_W - 1) / BANK_W;
    localparam int unsigned IRQ_ID_BASE     = 3;
    localparam int unsigned SYNC_STAGES     = 2;
    localparam int unsigned DEBOUNCE_CYCLES = 4;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ID_W    = 5;
    localparam int unsigned GRANT_W = 2;
    localparam int unsigned BIT_W   = $clog2(BANK_W);

    localparam logic [ADDR_W-1:0] ADDR_PEND0  = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_PEND1  = 4'h1;
    localparam logic [ADDR_W-1:0] ADDR_PEND2  = 4'h2;
    localparam logic [ADDR_W-1:0] ADDR_EN0    = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_EN1    = 4'h5;
    localparam logic [ADDR_W-1:0] ADDR_EN2    = 4'h6;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'h8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Bank holding a given gpio
    function automatic logic [GRANT_W-1:0] gpio_bank(input int unsigned idx);
        return GRANT_W'(idx / BANK_W);
    endfunction

    // Bit position of a given gpio inside its bank
    function automatic logic [BIT_W-1:0] gpio_bit(input int unsigned idx);
        return BIT_W'(idx % BANK_W);
    endfunction

    // Bits of a bank that map onto real gpio lines
    function automatic logic [BANK_W-1:0] bank_mask(input int unsigned bank);
        logic [BANK_W-1:0] m;
        m = '0;
        for (int unsigned j = 0; j < BANK_W; j++) begin
            if (bank * BANK_W + j < NUM_GPIO) m[j] = 1'b1;
        end
        return m;
    endfunction

    // Next bank in round-robin order
    function automatic logic [GRANT_W-1:0] bank_inc(input logic [GRANT_W-1:0] b);
        return (b == GRANT_W'(NUM_BANKS - 1)) ? '0 : b + GRANT_W'(1);
    endfunction

endpackage

// File: rtl/gpio_edge_detect.sv
// Per-pin synchroniser, optional debounce filter and registered rising-edge pulse.
// GPIO_IRQ_DEBOUNCE_EN inserts a DEBOUNCE_CYCLES stability filter before edge detection.
module gpio_edge_detect
    import gpio_irq_pkg::*;
#(
    parameter int unsigned WIDTH  = NUM_GPIO,
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] prev_q;

    // Synchroniser chain for the asynchronous pins
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= pin;
            for (int unsigned s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // Filtered level follows the raw level only after it has been stable long enough
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync_q[STAGES-1][i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt_q[i] <= sync_q[STAGES-1][i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[STAGES-1];
`endif

    // Previous-value register and one-cycle rising-edge pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            rise   <= '0;
        end else begin
            prev_q <= level;
            rise   <= level & ~prev_q;
        end
    end

endmodule

// File: rtl/gpio_irq_arbiter.sv
// Collects GPIO rising edges into pending banks and raises one interrupt per bank,
// arbitrated round-robin. Build option: GPIO_IRQ_DEBOUNCE_EN (input debounce filter).
module gpio_irq_arbiter
    import gpio_irq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_GPIO-1:0] gpio_i,
    input  logic                cfg_we,
    input  logic                cfg_re,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]   cfg_wdata,
    output logic [DATA_W-1:0]   cfg_rdata,
    output logic                irq_o,
    output logic [ID_W-1:0]     irq_id_o,
    input  logic                irq_ack_i
);

    typedef logic [NUM_BANKS-1:0][BANK_W-1:0] bank_vec_t;

    logic [NUM_GPIO-1:0]  rise;
    bank_vec_t            pend_q, pend_nxt, pend_set;
    bank_vec_t            en_q, en_nxt;
    logic [NUM_BANKS-1:0] wr_pend, wr_en, req;
    logic [DATA_W-1:0]    rdata_c;

    irq_state_t           state_q, state_nxt;
    logic [GRANT_W-1:0]   grant_q, grant_nxt;
    logic [GRANT_W-1:0]   rr_q, rr_nxt;
    logic [GRANT_W-1:0]   pick, cand;
    logic                 found;
    logic                 irq_nxt;
    logic [ID_W-1:0]      irq_id_nxt;
    logic                 holdoff_q, holdoff_nxt;

    gpio_edge_detect #(
        .WIDTH  (NUM_GPIO),
        .STAGES (SYNC_STAGES)
    ) u_edge (
        .clk   (clk),
        .reset (reset),
        .pin   (gpio_i),
        .rise  (rise)
    );

    // Scatter edge pulses into their bank/bit positions
    always_comb begin
        pend_set = '0;
        for (int unsigned i = 0; i < NUM_GPIO; i++) begin
            pend_set[gpio_bank(i)][gpio_bit(i)] = rise[i];
        end
    end

    // Register write decode
    always_comb begin
        wr_pend = '0;
        wr_en   = '0;
        if (cfg_we) begin
            case (cfg_addr)
                ADDR_PEND0: wr_pend[0] = 1'b1;
                ADDR_PEND1: wr_pend[1] = 1'b1;
                ADDR_PEND2: wr_pend[2] = 1'b1;
                ADDR_EN0:   wr_en[0]   = 1'b1;
                ADDR_EN1:   wr_en[1]   = 1'b1;
                ADDR_EN2:   wr_en[2]   = 1'b1;
                default:    ;
            endcase
        end
    end

    // Pending/enable next values; a new edge beats a same-cycle W1C
    always_comb begin
        pend_nxt = pend_q;
        en_nxt   = en_q;
        req      = '0;
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            pend_nxt[k] = ((pend_q[k] & ~(wr_pend[k] ? cfg_wdata : '0)) | pend_set[k])
                          & bank_mask(k);
            en_nxt[k]   = wr_en[k] ? (cfg_wdata & bank_mask(k)) : en_q[k];
            req[k]      = |(pend_q[k] & en_q[k]);
        end
    end

    // Pending and enable storage
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            en_q   <= '0;
        end else begin
            pend_q <= pend_nxt;
            en_q   <= en_nxt;
        end
    end

    // Register read mux
    always_comb begin
        rdata_c = '0;
        case (cfg_addr)
            ADDR_PEND0:  rdata_c = pend_q[0];
            ADDR_PEND1:  rdata_c = pend_q[1];
            ADDR_PEND2:  rdata_c = pend_q[2];
            ADDR_EN0:    rdata_c = en_q[0];
            ADDR_EN1:    rdata_c = en_q[1];
            ADDR_EN2:    rdata_c = en_q[2];
            ADDR_STATUS: rdata_c = DATA_W'({(state_q != IDLE), grant_q, 2'b00});
            default:     rdata_c = '0;
        endcase
    end

    // Read data register, holds its value between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_rdata <= '0;
        end else if (cfg_re) begin
            cfg_rdata <= rdata_c;
        end
    end

    // Arbiter next-state and registered irq outputs
    always_comb begin
        state_nxt   = state_q;
        grant_nxt   = grant_q;
        rr_nxt      = rr_q;
        irq_nxt     = irq_o;
        irq_id_nxt  = irq_id_o;
        holdoff_nxt = 1'b0;

        found = 1'b0;
        pick  = rr_q;
        cand  = rr_q;
        for (int unsigned o = 0; o < NUM_BANKS; o++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = bank_inc(cand);
        end

        case (state_q)
            IDLE: begin
                // holdoff guarantees an idle cycle after a completed service
                if (!holdoff_q && found) begin
                    state_nxt  = ASSERT;
                    grant_nxt  = pick;
                    irq_nxt    = 1'b1;
                    irq_id_nxt = ID_W'(IRQ_ID_BASE) + ID_W'(pick);
                end
            end
            ASSERT: begin
                if (irq_ack_i) begin
                    state_nxt = SERVICE;
                    irq_nxt   = 1'b0;
                end else if (!req[grant_q]) begin
                    // software withdrew the request: retry without moving rr
                    state_nxt = IDLE;
                    irq_nxt   = 1'b0;
                end
            end
            SERVICE: begin
                if (!req[grant_q]) begin
                    state_nxt   = IDLE;
                    rr_nxt      = bank_inc(grant_q);
                    holdoff_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                irq_nxt   = 1'b0;
            end
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            irq_o     <= 1'b0;
            irq_id_o  <= '0;
            holdoff_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            grant_q   <= grant_nxt;
            rr_q      <= rr_nxt;
            irq_o     <= irq_nxt;
            irq_id_o  <= irq_id_nxt;
            holdoff_q <= holdoff_nxt;
        end
    end

endmodule

// File: tb/tb_gpio_irq_arbiter.sv
// Self-checking bench for gpio_irq_arbiter: directed steps plus random edges
// checked against a bank/round-robin reference model.
module tb_gpio_irq_arbiter;
    import gpio_irq_pkg::*;

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int EXTRA     = DEBOUNCE_CYCLES;
    localparam int PULSE_LEN = DEBOUNCE_CYCLES + 2;
`else
    localparam int EXTRA     = 0;
    localparam int PULSE_LEN = 2;
`endif
    localparam int SETTLE = 8 + EXTRA;

    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] gpio_i;
    logic        cfg_we, cfg_re;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        irq_o;
    logic [4:0]  irq_id_o;
    logic        irq_ack_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_pend [3];
    logic [31:0] model_en   [3];
    int          rr_m;
    int          got_ids [$];

    gpio_irq_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .gpio_i    (gpio_i),
        .cfg_we    (cfg_we),
        .cfg_re    (cfg_re),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_o     (irq_o),
        .irq_id_o  (irq_id_o),
        .irq_ack_i (irq_ack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] valid_mask(input int b);
        return (b == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
        cfg_re = 1'b1; cfg_addr = a;
        tick();
        cfg_re = 1'b0;
        d = cfg_rdata;
    endtask

    task automatic set_en(input int b, input logic [31:0] v);
        cfg_write(4'(4 + b), v);
        model_en[b] = v & valid_mask(b);
    endtask

    task automatic pulse(input logic [71:0] v);
        for (int i = 0; i < 72; i++) if (v[i]) model_pend[i / 32][i % 32] = 1'b1;
        gpio_i = v;
        repeat (PULSE_LEN) tick();
        gpio_i = '0;
    endtask

    task automatic check_pends(input string tag);
        logic [31:0] d;
        for (int b = 0; b < 3; b++) begin
            cfg_read(4'(b), d);
            check($sformatf("%s_pend%0d", tag, b), d, model_pend[b]);
        end
    endtask

    task automatic wait_irq();
        int n;
        n = 0;
        while (irq_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("irq_wait", 32'(irq_o), 32'd1);
    endtask

    // Serve every requesting bank in the order the round-robin rule dictates
    task automatic serve_expected(input string tag);
        logic [2:0] r;
        int g;
        for (int b = 0; b < 3; b++) r[b] = |(model_pend[b] & model_en[b]);
        while (r != 3'b000) begin
            g = -1;
            for (int o = 0; o < 3; o++) if (g < 0 && r[(rr_m + o) % 3]) g = (rr_m + o) % 3;
            wait_irq();
            check($sformatf("%s_id", tag), 32'(irq_id_o), 32'(3 + g));
            got_ids.push_back(int'(irq_id_o));
            irq_ack_i = 1'b1;
            tick();
            irq_ack_i = 1'b0;
            check($sformatf("%s_ackdrop", tag), 32'(irq_o), 32'd0);
            cfg_write(4'(g), 32'hFFFF_FFFF);
            model_pend[g] = '0;
            r[g] = 1'b0;
            rr_m = (g + 1) % 3;
        end
        repeat (6) tick();
        check($sformatf("%s_quiet", tag), 32'(irq_o), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [71:0] v;
        int k;

        reset = 1'b1; gpio_i = '0; cfg_we = 1'b0; cfg_re = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; irq_ack_i = 1'b0;
        for (int b = 0; b < 3; b++) begin model_pend[b] = '0; model_en[b] = '0; end
        rr_m = 0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_id", 32'(irq_id_o), 32'd0);
        check("rst_rdata", cfg_rdata, 32'd0);

        // Bank0 basic with exact latency
        set_en(0, 32'hFFFF_FFFF);
        model_pend[0][5] = 1'b1;
        gpio_i[5] = 1'b1;
        for (int t = 1; t <= 5 + EXTRA; t++) begin
            tick();
            if (t == PULSE_LEN) gpio_i[5] = 1'b0;
            if (t == 4 + EXTRA) check("b0_irq_early", 32'(irq_o), 32'd0);
            if (t == 5 + EXTRA) check("b0_irq_rise", 32'(irq_o), 32'd1);
        end
        gpio_i = '0;
        check("b0_id", 32'(irq_id_o), 32'd3);
        cfg_read(4'h0, d);
        check("b0_pend", d, 32'h0000_0020);
        cfg_read(4'h8, d);
        check("b0_status_busy", d, 32'h0000_0010);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check("b0_ack", 32'(irq_o), 32'd0);
        cfg_write(4'h0, 32'h0000_0020);
        model_pend[0] = '0;
        repeat (4) tick();
        check("b0_stays_low", 32'(irq_o), 32'd0);
        cfg_read(4'h8, d);
        check("b0_status_idle", 32'(d[4]), 32'd0);
        rr_m = 1;

        // Bank2 basic and unused-bit masking
        set_en(2, 32'h0000_00FF);
        v = '0; v[70] = 1'b1;
        pulse(v);
        repeat (SETTLE) tick();
        check_pends("b2");
        serve_expected("b2");
        set_en(2, 32'hFFFF_FFFF);
        cfg_read(4'h6, d);
        check("b2_en_mask", d, 32'h0000_00FF);

        // Sweep every gpio
        set_en(1, 32'hFFFF_FFFF);
        for (int i = 0; i < 72; i++) begin
            v = '0; v[i] = 1'b1;
            pulse(v);
            repeat (SETTLE) tick();
            check_pends($sformatf("sweep%0d", i));
            serve_expected($sformatf("sweep%0d", i));
        end

        // Round robin from rr=0, then from rr=1
        got_ids.delete();
        v = '0; v[0] = 1'b1; v[40] = 1'b1; v[65] = 1'b1;
        pulse(v);
        serve_expected("rr0");
        check("rr0_order", 32'(got_ids.size() == 3 ? got_ids[0] * 100 + got_ids[1] * 10 + got_ids[2] : 0), 32'd345);
        v = '0; v[1] = 1'b1;
        pulse(v);
        serve_expected("rr_pre");
        got_ids.delete();
        v = '0; v[0] = 1'b1; v[40] = 1'b1; v[65] = 1'b1;
        pulse(v);
        serve_expected("rr1");
        check("rr1_order", 32'(got_ids.size() == 3 ? got_ids[0] * 100 + got_ids[1] * 10 + got_ids[2] : 0), 32'd453);

        // Random edges with random enables
        for (int it = 0; it < 16; it++) begin
            for (int b = 0; b < 3; b++) set_en(b, $urandom);
            v = '0;
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) v[$urandom_range(0, 71)] = 1'b1;
            pulse(v);
            repeat (SETTLE) tick();
            check_pends($sformatf("rnd%0d", it));
            serve_expected($sformatf("rnd%0d", it));
            for (int b = 0; b < 3; b++) begin
                cfg_write(4'(b), 32'hFFFF_FFFF);
                model_pend[b] = '0;
            end
            repeat (4) tick();
        end

        // Masking and edge/W1C collision
        set_en(0, 32'hFFFF_FFFF);
        set_en(1, 32'h0);
        set_en(2, 32'hFF);
        v = '0; v[33] = 1'b1;
        pulse(v);
        repeat (SETTLE) tick();
        check_pends("mask");
        check("mask_no_irq", 32'(irq_o), 32'd0);
        gpio_i[33] = 1'b1;
        for (int t = 1; t <= 4 + EXTRA; t++) begin
            if (t == 4 + EXTRA) begin cfg_we = 1'b1; cfg_addr = 4'h1; cfg_wdata = 32'h2; end
            tick();
            if (t == PULSE_LEN) gpio_i[33] = 1'b0;
        end
        cfg_we = 1'b0;
        gpio_i = '0;
        cfg_read(4'h1, d);
        check("collision_set_wins", d, 32'h0000_0002);
        set_en(1, 32'h2);
        wait_irq();
        check("mask_en_id", 32'(irq_id_o), 32'd4);
        cfg_read(4'h8, d);
        check("assert_status", d, 32'h0000_0014);

        // Reset while asserting
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_assert_irq", 32'(irq_o), 32'd0);
        check("rst_assert_rdata", cfg_rdata, 32'd0);
        for (int b = 0; b < 3; b++) begin model_pend[b] = '0; model_en[b] = '0; end
        rr_m = 0;
        check_pends("rst");
        for (int b = 0; b < 3; b++) begin
            cfg_read(4'(4 + b), d);
            check($sformatf("rst_en%0d", b), d, 32'd0);
        end
        repeat (4) tick();
        check("rst_quiet", 32'(irq_o), 32'd0);

`ifdef GPIO_IRQ_DEBOUNCE_EN
        // Short glitch is filtered, long pulse is recorded
        gpio_i[10] = 1'b1;
        repeat (2) tick();
        gpio_i = '0;
        repeat (SETTLE + 4) tick();
        cfg_read(4'h0, d);
        check("deb_short", d, 32'd0);
        v = '0; v[10] = 1'b1;
        pulse(v);
        repeat (SETTLE) tick();
        cfg_read(4'h0, d);
        check("deb_long", d, 32'h0000_0400);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
